// File: rtl/pair_loader_pkg.sv
// Shared definitions for the pair loader and the downstream sorter bench:
// FSM state encoding, default element width and padding fill values.
package pair_loader_pkg;

    // EMPTY: nothing held, HALF: first element in hold, FULL: pair presented
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Fill bit for the padding element; padding must sort to the tail, so an
    // ascending pair is padded with all-ones and a descending pair with zeros.
    localparam logic PAD_FILL_ASC  = 1'b1;
    localparam logic PAD_FILL_DESC = 1'b0;

    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/pair_loader.sv
// Pair loader: groups an element stream into pairs for a two-input sorter.
// Odd groups get their last element padded; the sort direction alternates
// per pair (optionally) and restarts ascending at every group boundary.
module pair_loader
    import pair_loader_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit ALT_DIR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic                 stall,
    output logic [WIDTH-1:0]     pair_a,
    output logic [WIDTH-1:0]     pair_b,
    output logic                 pair_dir,
    output logic                 pair_en,
    output logic                 pair_last,
    output logic [CNT_WIDTH-1:0] pair_cnt
);

    state_t           state_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             dir_reg;      // direction the next formed pair will use
    logic             full;
    logic             accept;
    logic             emit_dir_next;
    logic             load_dir;
    logic [WIDTH-1:0] pad;

    assign full     = (state_reg == ST_FULL);
    assign pair_en  = full && !stall;
    assign in_ready = !full || !stall;
    assign accept   = in_valid && in_ready;

    // Direction following the pair currently presented: a group boundary
    // restarts ascending, otherwise alternate (or stay ascending if disabled).
    assign emit_dir_next = pair_last ? 1'b0 : (ALT_DIR ? ~pair_dir : 1'b0);

    // A pair loaded while the previous one is leaving must already see the
    // updated direction, since dir_reg only catches up on the same edge.
    assign load_dir = full ? emit_dir_next : dir_reg;
    assign pad      = {WIDTH{load_dir ? PAD_FILL_DESC : PAD_FILL_ASC}};

    // FSM with hold register, registered pair outputs, direction and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            hold_reg  <= '0;
            dir_reg   <= 1'b0;
            pair_a    <= '0;
            pair_b    <= '0;
            pair_dir  <= 1'b0;
            pair_last <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            if (pair_en) begin
                pair_cnt <= pair_cnt + 1'b1;
                dir_reg  <= emit_dir_next;
            end
            case (state_reg)
                ST_HALF: begin
                    if (accept) begin
                        pair_a    <= hold_reg;
                        pair_b    <= in_data;
                        pair_last <= in_last;
                        pair_dir  <= load_dir;
                        state_reg <= ST_FULL;
                    end
                end
                default: begin
                    // EMPTY, or FULL with the pair leaving this cycle; in FULL
                    // an accept implies pair_en because in_ready needs !stall.
                    if (accept) begin
                        if (in_last) begin
                            pair_a    <= in_data;
                            pair_b    <= pad;
                            pair_last <= 1'b1;
                            pair_dir  <= load_dir;
                            state_reg <= ST_FULL;
                        end else begin
                            hold_reg  <= in_data;
                            state_reg <= ST_HALF;
                        end
                    end else if (pair_en) begin
                        state_reg <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_loader.sv
`timescale 1ns/1ps
module tb_pair_loader;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          stall = 1'b0;

    logic          in_ready,  in_ready0;
    logic [W-1:0]  pair_a,    pair_a0;
    logic [W-1:0]  pair_b,    pair_b0;
    logic          pair_dir,  pair_dir0;
    logic          pair_en,   pair_en0;
    logic          pair_last, pair_last0;
    logic [15:0]   pair_cnt,  pair_cnt0;

    pair_loader #(.WIDTH(W), .ALT_DIR(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .stall(stall),
        .pair_a(pair_a), .pair_b(pair_b), .pair_dir(pair_dir),
        .pair_en(pair_en), .pair_last(pair_last), .pair_cnt(pair_cnt)
    );

    pair_loader #(.WIDTH(W), .ALT_DIR(1'b0)) dut_fix (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready0), .stall(stall),
        .pair_a(pair_a0), .pair_b(pair_b0), .pair_dir(pair_dir0),
        .pair_en(pair_en0), .pair_last(pair_last0), .pair_cnt(pair_cnt0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         dir;
        logic         last;
    } pair_t;

    pair_t        q[$];
    bit           m_has_first = 1'b0;
    logic [W-1:0] m_first = '0;
    logic         m_dir = 1'b0;
    logic [15:0]  m_cnt = 16'd0;

    function automatic void model_reset();
        q.delete();
        m_has_first = 1'b0;
        m_dir       = 1'b0;
        m_cnt       = 16'd0;
    endfunction

    function automatic void model_push(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic last);
        pair_t p;
        p.a = a; p.b = b; p.dir = m_dir; p.last = last;
        q.push_back(p);
        m_dir = last ? 1'b0 : ~m_dir;
    endfunction

    function automatic void model_accept(input logic [W-1:0] d, input logic l);
        if (!m_has_first) begin
            if (l) model_push(d, m_dir ? {W{1'b0}} : {W{1'b1}}, 1'b1);
            else begin
                m_has_first = 1'b1;
                m_first     = d;
            end
        end else begin
            model_push(m_first, d, l);
            m_has_first = 1'b0;
        end
    endfunction

    task automatic tick();
        bit exp_full, exp_en, exp_rdy;
        @(negedge clk);
        if (rst) begin
            chk("rst_en", pair_en, 1'b0);
            chk("rst_rdy", in_ready, 1'b1);
            chk("rst_a", pair_a, {W{1'b0}});
            chk("rst_b", pair_b, {W{1'b0}});
            chk("rst_dir", pair_dir, 1'b0);
            chk("rst_last", pair_last, 1'b0);
            chk("rst_cnt", pair_cnt, 16'd0);
            model_reset();
        end else begin
            exp_full = (q.size() > 0);
            exp_en   = exp_full && !stall;
            exp_rdy  = !exp_full || !stall;
            chk("en", pair_en, exp_en);
            chk("ready", in_ready, exp_rdy);
            chk("cnt", pair_cnt, m_cnt);
            chk("en_fix", pair_en0, exp_en);
            if (exp_full) begin
                chk("pair_a", pair_a, q[0].a);
                chk("pair_b", pair_b, q[0].b);
                chk("pair_dir", pair_dir, q[0].dir);
                chk("pair_last", pair_last, q[0].last);
                chk("dir_fix", pair_dir0, 1'b0);
                chk("a_fix", pair_a0, q[0].a);
            end
            if (exp_en) begin
                if (verbose)
                    $display("pair a=%0h b=%0h dir=%0d last=%0d cnt=%0d",
                             q[0].a, q[0].b, q[0].dir, q[0].last, m_cnt + 16'd1);
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (in_valid && exp_rdy) model_accept(in_data, in_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic l,
                         input logic s);
        in_valid = v; in_data = d; in_last = l; stall = s;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        #1;
        do_reset();
        idle(1);

        drive(1, 32'd5, 0, 0);
        drive(1, 32'd3, 0, 0);
        drive(1, 32'd8, 0, 0);
        drive(1, 32'd12, 1, 0);
        idle(2);
        total++;
        if (pair_cnt !== 16'd2) begin
            bad++;
            $display("FAIL grp_cnt observed=%0h expected=2", pair_cnt);
        end

        do_reset();
        drive(1, 32'd42, 0, 0);
        drive(1, 32'd18, 0, 0);
        drive(0, 32'd99, 0, 1);
        drive(1, 32'd77, 1, 1);
        drive(0, 32'd0, 0, 1);
        idle(2);
        total++;
        if (pair_cnt !== 16'd1) begin
            bad++;
            $display("FAIL stall_cnt observed=%0h expected=1", pair_cnt);
        end

        do_reset();
        drive(1, 32'd7, 1, 0);
        drive(1, 32'd9, 1, 0);
        idle(2);
        total++;
        if (pair_cnt !== 16'd2) begin
            bad++;
            $display("FAIL odd_cnt observed=%0h expected=2", pair_cnt);
        end

        do_reset();
        for (int i = 1; i <= 6; i++) drive(1, W'(i), (i == 6), 0);
        idle(2);
        total++;
        if (pair_cnt !== 16'd3) begin
            bad++;
            $display("FAIL b2b_cnt observed=%0h expected=3", pair_cnt);
        end

        do_reset();
        drive(1, 32'd25, 0, 0);
        do_reset();
        drive(1, 32'd30, 0, 0);
        drive(1, 32'd40, 1, 0);
        idle(2);
        total++;
        if (pair_cnt !== 16'd1) begin
            bad++;
            $display("FAIL rst_mid_cnt observed=%0h expected=1", pair_cnt);
        end

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive($urandom_range(0, 3) != 0, $urandom,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        idle(3);
        total++;
        if (pair_cnt !== m_cnt) begin
            bad++;
            $display("FAIL rand_cnt observed=%0h expected=%0h", pair_cnt, m_cnt);
        end

        do_reset();
        verbose = 1'b0;
        budget  = 0;
        while (m_cnt != 16'hFFFF && budget < 70000) begin
            drive(1, $urandom, 1, 0);
            budget++;
        end
        if (budget >= 70000) begin
            total++; bad++;
            $display("FAIL wrap_budget observed=%0d expected<70000", budget);
        end
        drive(0, '0, 0, 0);
        verbose = 1'b1;
        total++;
        if (pair_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_cnt observed=%0h expected=0", pair_cnt);
        end
        idle(1);
        total++;
        if (pair_en !== 1'b0) begin
            bad++;
            $display("FAIL wrap_idle_en observed=%0h expected=0", pair_en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
